// File: rtl/button_packet_decoder.sv
// -----------------------------------------------------------------------------
// button_packet_decoder
//
// Turns UDP payload words from network_stack_rx into committed NES button
// bytes for 1..N_PLAYERS controllers. Every button byte is sent together with
// its complement. Packets that are out of order or replayed are rejected by
// their 8-bit sequence number. A watchdog clears all buttons if no good packet
// arrives for TIMEOUT_CYCLES cycles.
//
// Packet: word0 = {MAGIC, seq}, word1..N_PLAYERS = {btn_p, ~btn_p};
//         the packet ends on the first cycle with axiiv = 0.
//
// State table:
//   SYNC | wait for a gap in axiiv (reset may be released mid-packet)
//   IDLE | between packets, header checked on the first valid word
//   BODY | collecting button words into the shadow bytes
//   DROP | malformed packet, discard words until the gap
//
// Ports:
//   clk        eth_refclk domain clock
//   rst        synchronous reset, active low
//   axiiv      payload word valid, high for the whole packet
//   axiid      payload word
//   buttons    committed buttons, player p in [8p+7:8p]
//   update     one-cycle pulse on each commit
//   link_lost  high while there is no valid link
//   good_cnt   accepted packets (saturating)
//   drop_cnt   malformed packets (saturating)
//   stale_cnt  sequence-rejected packets (saturating)
// -----------------------------------------------------------------------------
module button_packet_decoder #(
    parameter int           N_PLAYERS      = 2,
    parameter logic [7:0]   MAGIC          = 8'hB7,
    parameter int           TIMEOUT_CYCLES = 1000000,
    parameter int           CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axiiv,
    input  logic [15:0]            axiid,
    output logic [8*N_PLAYERS-1:0] buttons,
    output logic                   update,
    output logic                   link_lost,
    output logic [CNT_W-1:0]       good_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       stale_cnt
);

    localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam int             WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_TC   = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [2:0]     IDX_MAX  = 3'(N_PLAYERS);
    localparam logic [2:0]     IDX_FULL = 3'(N_PLAYERS + 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic [2:0]               idx, idx_nxt;
    logic [7:0]               seq_cur, seq_nxt;
    logic [7:0]               last_seq;
    logic                     seq_valid;
    logic [8*N_PLAYERS-1:0]   shadow;
    logic [WD_W-1:0]          watchdog;
    logic [7:0]               seq_diff;

    logic                     shadow_we;
    logic                     commit;
    logic                     drop_inc;
    logic                     stale_inc;

    assign seq_diff = seq_cur - last_seq;

    // The gap cycle that ends a BODY packet is the evaluation cycle: the
    // verdict is taken combinationally here and registered at its edge, so
    // the last word at cycle T shows up on buttons at T+2.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        seq_nxt   = seq_cur;
        shadow_we = 1'b0;
        commit    = 1'b0;
        drop_inc  = 1'b0;
        stale_inc = 1'b0;
        case (state)
            SYNC: begin
                if (!axiiv) state_nxt = IDLE;
            end
            IDLE: begin
                if (axiiv) begin
                    if (axiid[15:8] != MAGIC) begin
                        state_nxt = DROP;
                    end else begin
                        seq_nxt   = axiid[7:0];
                        idx_nxt   = 3'd1;
                        state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                if (axiiv) begin
                    if ((axiid[7:0] != ~axiid[15:8]) || (idx > IDX_MAX)) begin
                        state_nxt = DROP;
                    end else begin
                        shadow_we = 1'b1;
                        idx_nxt   = idx + 3'd1;
                    end
                end else begin
                    state_nxt = IDLE;
                    if (idx != IDX_FULL) begin
                        drop_inc = 1'b1;
                    end else if (seq_valid && ((seq_diff == 8'd0) || seq_diff[7])) begin
                        // diff of 0 is a replay, 128..255 is behind us (mod 256)
                        stale_inc = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!axiiv) begin
                    drop_inc  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SYNC;
            idx       <= 3'd0;
            seq_cur   <= 8'd0;
            last_seq  <= 8'd0;
            seq_valid <= 1'b0;
            shadow    <= '0;
            buttons   <= '0;
            update    <= 1'b0;
            link_lost <= 1'b1;
            watchdog  <= '0;
            good_cnt  <= '0;
            drop_cnt  <= '0;
            stale_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            seq_cur <= seq_nxt;
            update  <= commit;

            for (int p = 0; p < N_PLAYERS; p++) begin
                if (shadow_we && (idx == 3'(p + 1))) shadow[8*p +: 8] <= axiid[15:8];
            end

            // Commit has priority over a timeout landing on the same edge.
            if (commit) begin
                buttons   <= shadow;
                last_seq  <= seq_cur;
                seq_valid <= 1'b1;
                link_lost <= 1'b0;
                watchdog  <= '0;
            end else if (WD_EN && !link_lost) begin
                if (watchdog == WD_TC) begin
                    buttons   <= '0;
                    link_lost <= 1'b1;
                    seq_valid <= 1'b0;
                    watchdog  <= '0;
                end else begin
                    watchdog <= watchdog + WD_W'(1);
                end
            end

            if (commit && (good_cnt != '1))     good_cnt  <= good_cnt + CNT_W'(1);
            if (drop_inc && (drop_cnt != '1))   drop_cnt  <= drop_cnt + CNT_W'(1);
            if (stale_inc && (stale_cnt != '1)) stale_cnt <= stale_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_button_packet_decoder.sv
module tb_button_packet_decoder;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        axiiv = 1'b0;
    logic [15:0] axiid = 16'h0000;

    logic [15:0] buttons, buttons_s;
    logic        update, update_s, link_lost, link_lost_s;
    logic [15:0] good_cnt, drop_cnt, stale_cnt;
    logic [1:0]  good_s, drop_s, stale_s;

    button_packet_decoder #(.N_PLAYERS(2), .MAGIC(8'hB7), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .buttons(buttons), .update(update), .link_lost(link_lost),
        .good_cnt(good_cnt), .drop_cnt(drop_cnt), .stale_cnt(stale_cnt)
    );

    // narrow counters to exercise saturation
    button_packet_decoder #(.N_PLAYERS(2), .MAGIC(8'hB7), .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .buttons(buttons_s), .update(update_s), .link_lost(link_lost_s),
        .good_cnt(good_s), .drop_cnt(drop_s), .stale_cnt(stale_s)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] btn;
        int          due;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;

    logic [15:0] m_btn   = 16'h0;
    logic        m_lost  = 1'b1;
    logic        m_valid = 1'b0;
    logic [7:0]  m_last  = 8'h0;
    int          m_good = 0, m_drop = 0, m_stale = 0;
    int          m_commit_cyc = 0;

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // commit monitor: every update pulse must match the oldest expected commit
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (update) begin
                if (sb.size() == 0) begin
                    chk("spurious_update", update, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("commit_buttons", buttons, e.btn);
                    chk("commit_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic model_timeout();
        if (!m_lost && (cyc >= m_commit_cyc + TO)) begin
            m_lost  = 1'b1;
            m_valid = 1'b0;
            m_btn   = 16'h0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_buttons"},   buttons,   m_btn);
        chk({tag, "_link_lost"}, link_lost, m_lost);
        chk({tag, "_good"},      good_cnt,  m_good);
        chk({tag, "_drop"},      drop_cnt,  m_drop);
        chk({tag, "_stale"},     stale_cnt, m_stale);
        chk({tag, "_sat_good"},  good_s,    sat2(m_good));
        chk({tag, "_sat_drop"},  drop_s,    sat2(m_drop));
        chk({tag, "_sat_stale"}, stale_s,   sat2(m_stale));
        chk({tag, "_missing_update"}, sb.size(), 0);
    endtask

    task automatic send_pkt(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3, input int len);
        logic [15:0] w[4];
        logic [7:0]  d;
        bit          bad;
        int          due;
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = w[i];
        end
        @(negedge clk);
        axiiv = 1'b0;
        axiid = 16'h0;
        due = cyc + 1;
        model_timeout();
        bad = (w[0][15:8] != 8'hB7) || (len != 3);
        for (int i = 1; i < len; i++) begin
            if (w[i][7:0] != ~w[i][15:8]) bad = 1'b1;
        end
        if (bad) begin
            m_drop++;
        end else begin
            d = w[0][7:0] - m_last;
            if (m_valid && ((d == 8'd0) || (d >= 8'd128))) begin
                m_stale++;
            end else begin
                m_btn        = {w[2][15:8], w[1][15:8]};
                m_last       = w[0][7:0];
                m_valid      = 1'b1;
                m_lost       = 1'b0;
                m_commit_cyc = due;
                m_good++;
                sb.push_back('{btn: m_btn, due: due});
            end
        end
        repeat (2) @(negedge clk);
        model_timeout();
        check_outputs(tag);
    endtask

    function automatic logic [15:0] bw(input logic [7:0] b);
        return {b, ~b};
    endfunction

    initial begin
        logic [7:0] b0, b1;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_update", update, 1'b0);
        check_outputs("rst");
        rst = 1'b1;

        // basic commit
        send_pkt("t1", 16'hB701, 16'h12ED, 16'h8F70, 16'h0, 3);
        // complement error
        send_pkt("t2", 16'hB702, 16'h12ED, 16'h8F71, 16'h0, 3);
        // short, long, bad magic
        send_pkt("t3_short", 16'hB702, 16'h12ED, 16'h0, 16'h0, 2);
        send_pkt("t3_long",  16'hB702, 16'h12ED, 16'h8F70, 16'h00FF, 4);
        send_pkt("t3_magic", 16'hA503, 16'h12ED, 16'h8F70, 16'h0, 3);

        // stale: replay, behind, half-range away
        send_pkt("t4_replay", 16'hB701, 16'h33CC, 16'h44BB, 16'h0, 3);
        send_pkt("t4_behind", 16'hB700, 16'h33CC, 16'h44BB, 16'h0, 3);
        send_pkt("t4_far",    16'hB781, 16'h33CC, 16'h44BB, 16'h0, 3);
        send_pkt("t4_next",   16'hB702, 16'h55AA, 16'h6699, 16'h0, 3);
        for (int s = 3; s <= 256; s++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            send_pkt("t4_chain", {8'hB7, 8'(s)}, bw(b0), bw(b1), 16'h0, 3);
        end
        send_pkt("t4_jump", 16'hB740, bw(8'hA5), bw(8'h5A), 16'h0, 3);

        // watchdog
        while (cyc < m_commit_cyc + TO - 1) @(negedge clk);
        model_timeout();
        chk("t5_before_link", link_lost, m_lost);
        chk("t5_before_btn",  buttons,   m_btn);
        @(negedge clk);
        model_timeout();
        chk("t5_after_link", link_lost, m_lost);
        chk("t5_after_btn",  buttons,   m_btn);
        repeat (3) @(negedge clk);
        check_outputs("t5_idle");
        send_pkt("t5_seq37", 16'hB737, bw(8'h81), bw(8'h18), 16'h0, 3);

        // reset mid-body, released while the packet continues
        @(negedge clk); axiiv = 1'b1; axiid = 16'hB738;
        @(negedge clk); axiid = bw(8'h11);
        @(negedge clk); axiid = bw(8'h22); rst = 1'b0;
        @(negedge clk); axiid = bw(8'h33); rst = 1'b1;
        m_btn = 16'h0; m_lost = 1'b1; m_valid = 1'b0; m_last = 8'h0;
        m_good = 0; m_drop = 0; m_stale = 0;
        chk("t6_rst_update", update, 1'b0);
        check_outputs("t6_rst");
        @(negedge clk); axiid = bw(8'h44);
        @(negedge clk); axiid = 16'hB739;
        @(negedge clk); axiiv = 1'b0; axiid = 16'h0;
        repeat (3) @(negedge clk);
        check_outputs("t6_tail");
        send_pkt("t6_after", 16'hB737, bw(8'hC3), bw(8'h3C), 16'h0, 3);

        repeat (4) @(negedge clk);
        chk("end_queue", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
